vga_vblank_arbiter: RTL and testbench
=====================================

Name: vga_vblank_arbiter

Overview:
- Schedules and arbitrates access to the shared game-state resources (paddle/ball position registers, score RAM) between two game-side requesters.
- Access is granted only inside a safe vertical-blanking window derived from the sync generator's hsync/vsync outputs. The renderer therefore never reads half-updated state during active video.
- Sits between the VGA sync generator and the game logic, on the pixel clock domain.

Parameters:
- VPULSE, 6, vsync pulse length in lines (must match the sync generator).
- VBP, 23, vertical back porch in lines (must match the sync generator).
- GUARD_LINES, 2, lines before active video in which no grant may be held.
- MAX_BURST, 64, maximum cycles a single grant may be held before forced release.
- WIN_LINES, VPULSE+VBP-GUARD_LINES, derived; window length in hsync falling edges (default 27).

Ports:
- px_clk  in  1  pixel clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- hsync  in  1  active-low horizontal sync from the sync generator (synchronous to px_clk).
- vsync  in  1  active-low vertical sync from the sync generator (synchronous to px_clk).
- req  in  2  request per requester; level, held until served.
- done  in  2  one-cycle release pulse from the current owner.
- gnt  out  2  one-hot grant (00 = none).
- window  out  1  high while the blanking access window is open.
- overrun  out  1  one-cycle pulse when a grant is revoked by window close.
- frame_cnt  out  16  frame counter.

Behaviour:
- Reset state (rstn low, asynchronous):
  - gnt=00, window=0, overrun=0, frame_cnt=0.
  - line_cnt=0, burst_cnt=0, state=CLOSED.
  - last-granted pointer=1, so requester 0 wins the first tie.
- Edge detect:
  - hsync and vsync are registered once (hs_d, vs_d); no synchronisers.
  - vs_fall = vs_d & ~vsync; hs_fall = hs_d & ~hsync.
- frame_cnt increments by 1 on every vs_fall and wraps from 0xFFFF to 0.
- Window:
  - On vs_fall: line_cnt <= 0 and window <= 1 (visible the cycle after vs_fall).
  - While window=1, each hs_fall increments line_cnt.
  - On the hs_fall where line_cnt+1 == WIN_LINES: window <= 0.
  - A vs_fall while the window is already open restarts line_cnt; window stays 1 and any grant is kept.
- State machine, states CLOSED, ARB, OWN:
  - CLOSED: gnt=00. Go to ARB when window rises.
  - ARB: if window=0, go to CLOSED. Else, if any req is set, grant the requester chosen round-robin: prefer the one not equal to the pointer, else the other. gnt is set on the next edge; burst_cnt <= 0; pointer <= granted index; go to OWN. If no req, stay in ARB.
  - OWN: burst_cnt increments each cycle.
    - Release when done[owner]=1, OR req[owner]=0, OR burst_cnt == MAX_BURST-1. On release: gnt <= 00, go to ARB.
    - There is a mandatory one-cycle dead gap (gnt=00) between any two grants.
    - If window falls while in OWN: gnt <= 00 on that same edge, overrun pulses 1 cycle, go to CLOSED. Revoke takes precedence over done in the same cycle, but overrun is suppressed if done[owner] is also 1 that cycle.
  - done on a non-owner bit, or with gnt=00, is ignored.
- Latency:
  - req to gnt: 1 cycle from ARB with the window open.
  - window open to first possible gnt: 2 cycles after vs_fall.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt is never nonzero while window=0.

Test Plan:
- Reset and idle: hold rstn low with vsync toggling -> all outputs 0. Release, drive one vsync falling edge -> frame_cnt=1, window=1 two cycles later.
- Window length: defaults, count hsync falling edges after vs_fall -> window falls after exactly 27 hs_fall; no gnt outside the window even with req=11 held.
- Round-robin: req=11 held, each owner pulses done 3 cycles after its grant -> gnt sequence 01,00,10,00,01, with one dead cycle between grants.
- Burst limit: req=01 held, done never pulsed -> gnt=01 for exactly 64 cycles, then 00 for 1 cycle, then 01 again.
- Overrun: grant taken 2 cycles before the closing hs_fall, no done -> gnt=00 on the close edge, overrun=1 for one cycle, state CLOSED. Repeat with done asserted on the same cycle -> overrun stays 0.
- Async reset mid-grant: assert rstn low while gnt=10 -> gnt=00 and frame_cnt=0 immediately, without waiting for a px_clk edge; after release, first grant goes to requester 0 on req=11.

Source files
------------

// File: rtl/vga_vblank_arbiter.sv
// Grants two game-side requesters access to shared game state, but only inside the
// vertical-blanking window measured from the sync generator's hsync/vsync edges.
module vga_vblank_arbiter #(
  parameter int VPULSE      = 6,
  parameter int VBP         = 23,
  parameter int GUARD_LINES = 2,
  parameter int MAX_BURST   = 64,
  parameter int WIN_LINES   = VPULSE + VBP - GUARD_LINES
) (
  input  logic        px_clk,
  input  logic        rstn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [1:0]  req,
  input  logic [1:0]  done,
  output logic [1:0]  gnt,
  output logic        window,
  output logic        overrun,
  output logic [15:0] frame_cnt
);

  // state  | meaning
  // CLOSED | blanking window shut, nobody may own the resources
  // ARB    | window open, choosing the next owner (also the dead gap)
  // OWN    | requester ptr holds the resources
  typedef enum logic [1:0] {CLOSED, ARB, OWN} state_t;

  localparam int LW = $clog2(WIN_LINES + 1);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [LW-1:0] LINE_LAST  = LW'(WIN_LINES - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_t        state, state_nxt;
  logic          hs_d, vs_d;
  logic          hs_fall, vs_fall, win_close;
  logic [LW-1:0] line_cnt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          ptr, ptr_nxt, pick;
  logic          overrun_nxt;

  assign vs_fall = vs_d & ~vsync;
  assign hs_fall = hs_d & ~hsync;
  // A restarting vsync keeps the window open even on the would-be last line.
  assign win_close = window & hs_fall & ~vs_fall & (line_cnt == LINE_LAST);
  assign pick = req[~ptr] ? ~ptr : ptr;

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      window    <= 1'b0;
      line_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      hs_d <= hsync;
      vs_d <= vsync;
      if (vs_fall) begin
        line_cnt  <= '0;
        window    <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (window && hs_fall) begin
        line_cnt <= line_cnt + LW'(1);
        if (win_close) window <= 1'b0;
      end
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= CLOSED;
      burst_cnt <= '0;
      ptr       <= 1'b1;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      ptr       <= ptr_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    ptr_nxt     = ptr;
    overrun_nxt = 1'b0;
    case (state)
      CLOSED: begin
        if (window) state_nxt = ARB;
      end
      ARB: begin
        // Never grant on the edge that closes the window.
        if (!window || win_close) begin
          state_nxt = CLOSED;
        end else if (|req) begin
          state_nxt = OWN;
          burst_nxt = '0;
          ptr_nxt   = pick;
        end
      end
      OWN: begin
        if (win_close) begin
          state_nxt   = CLOSED;
          overrun_nxt = ~done[ptr];
        end else if (done[ptr] || !req[ptr] || burst_cnt == BURST_LAST) begin
          state_nxt = ARB;
        end else begin
          burst_nxt = burst_cnt + BW'(1);
        end
      end
      default: state_nxt = CLOSED;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (state == OWN) gnt[ptr] = 1'b1;
  end

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// Bench for vga_vblank_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level model of the window, frame counter and grant rules.
module tb_vga_vblank_arbiter;

  localparam int WIN   = 27;
  localparam int BURST = 64;

  logic        px_clk = 1'b0;
  logic        rstn   = 1'b1;
  logic        hsync  = 1'b1;
  logic        vsync  = 1'b1;
  logic [1:0]  req    = 2'b00;
  logic [1:0]  done   = 2'b00;
  logic [1:0]  gnt;
  logic        window;
  logic        overrun;
  logic [15:0] frame_cnt;

  int vec  = 0;
  int errs = 0;

  int          m_lines, m_held, m_last;
  logic        m_window, m_prev_win, m_overrun, m_hs_prev, m_vs_prev;
  logic [1:0]  m_gnt;
  logic [15:0] m_frame;

  vga_vblank_arbiter dut (
    .px_clk    (px_clk),
    .rstn      (rstn),
    .hsync     (hsync),
    .vsync     (vsync),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .window    (window),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 px_clk = ~px_clk;

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    req   = 2'b00;
    done  = 2'b00;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // One vsync falling edge; returns with the arbiter in its open, idle state.
  task automatic open_window();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vsync = ~vsync;
      tick();
      vec++;
      if ({gnt, window, overrun, frame_cnt} !== 20'h0) begin
        errs++;
        $display("FAIL reset_hold[%0d] gnt=%b window=%b overrun=%b frame_cnt=%0d expected all zero",
                 i, gnt, window, overrun, frame_cnt);
      end
    end
    vsync = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    tick();
    vec++;
    if ({gnt, window, overrun, frame_cnt} !== 20'h0) begin
      errs++;
      $display("FAIL reset_idle gnt=%b window=%b overrun=%b frame_cnt=%0d expected all zero",
               gnt, window, overrun, frame_cnt);
    end
    vsync = 1'b0;
    tick();
    vec++;
    if (frame_cnt !== 16'd1 || window !== 1'b1) begin
      errs++;
      $display("FAIL first_vsync frame_cnt=%0d window=%b expected frame_cnt=1 window=1", frame_cnt, window);
    end
    vsync = 1'b1;
    tick();
    vec++;
    if (frame_cnt !== 16'd1 || window !== 1'b1 || gnt !== 2'b00) begin
      errs++;
      $display("FAIL after_vsync frame_cnt=%0d window=%b gnt=%b expected 1 1 00", frame_cnt, window, gnt);
    end
  endtask

  task automatic test_window();
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (gnt !== 2'b00) begin
        errs++;
        $display("FAIL pre_window_gnt gnt=%b expected 00", gnt);
      end
    end
    open_window();
    for (int k = 1; k <= WIN; k++) begin
      hsync = 1'b0;
      tick();
      vec++;
      if (window !== (k < WIN)) begin
        errs++;
        $display("FAIL window_len line=%0d window=%b expected %b", k, window, (k < WIN));
      end
      hsync = 1'b1;
      tick();
      vec++;
      if (!window && gnt !== 2'b00) begin
        errs++;
        $display("FAIL gnt_outside_window line=%0d gnt=%b expected 00", k, gnt);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      vec++;
      if ({window, gnt} !== 3'b000) begin
        errs++;
        $display("FAIL closed_idle window=%b gnt=%b expected 0 00", window, gnt);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    open_window();
    req = 2'b11;
    exp = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++;
      if (gnt !== exp) begin
        errs++;
        $display("FAIL rr_grant[%0d] gnt=%b expected %b", i, gnt, exp);
      end
      done = ~exp;
      tick();
      vec++;
      if (gnt !== exp) begin
        errs++;
        $display("FAIL rr_foreign_done[%0d] gnt=%b expected %b", i, gnt, exp);
      end
      done = 2'b00;
      tick();
      vec++;
      if (gnt !== exp) begin
        errs++;
        $display("FAIL rr_hold[%0d] gnt=%b expected %b", i, gnt, exp);
      end
      done = exp;
      tick();
      vec++;
      if (gnt !== 2'b00) begin
        errs++;
        $display("FAIL rr_dead_gap[%0d] gnt=%b expected 00", i, gnt);
      end
      done = 2'b00;
      exp  = ~exp;
    end
    req = 2'b00;
  endtask

  task automatic test_burst();
    do_reset();
    open_window();
    req = 2'b01;
    for (int i = 0; i < BURST; i++) begin
      tick();
      vec++;
      if (gnt !== 2'b01) begin
        errs++;
        $display("FAIL burst_hold cycle=%0d gnt=%b expected 01", i, gnt);
      end
    end
    tick();
    vec++;
    if (gnt !== 2'b00) begin
      errs++;
      $display("FAIL burst_release gnt=%b expected 00", gnt);
    end
    tick();
    vec++;
    if (gnt !== 2'b01) begin
      errs++;
      $display("FAIL burst_regrant gnt=%b expected 01", gnt);
    end
    req = 2'b00;
  endtask

  task automatic test_overrun(input logic with_done);
    do_reset();
    open_window();
    for (int k = 0; k < WIN - 1; k++) begin
      hsync = 1'b0;
      tick();
      hsync = 1'b1;
      tick();
    end
    req = 2'b01;
    tick();
    vec++;
    if (gnt !== 2'b01) begin
      errs++;
      $display("FAIL ovr_grant done=%b gnt=%b expected 01", with_done, gnt);
    end
    tick();
    vec++;
    if (gnt !== 2'b01 || window !== 1'b1) begin
      errs++;
      $display("FAIL ovr_hold done=%b gnt=%b window=%b expected 01 1", with_done, gnt, window);
    end
    hsync = 1'b0;
    done  = with_done ? 2'b01 : 2'b00;
    tick();
    vec++;
    if (gnt !== 2'b00 || window !== 1'b0 || overrun !== !with_done) begin
      errs++;
      $display("FAIL ovr_revoke done=%b gnt=%b window=%b overrun=%b expected 00 0 %b",
               with_done, gnt, window, overrun, !with_done);
    end
    hsync = 1'b1;
    done  = 2'b00;
    tick();
    vec++;
    if (overrun !== 1'b0 || gnt !== 2'b00) begin
      errs++;
      $display("FAIL ovr_pulse_len done=%b overrun=%b gnt=%b expected 0 00", with_done, overrun, gnt);
    end
    tick();
    tick();
    vec++;
    if (gnt !== 2'b00) begin
      errs++;
      $display("FAIL ovr_closed done=%b gnt=%b expected 00", with_done, gnt);
    end
    req = 2'b00;
  endtask

  task automatic test_async_reset();
    do_reset();
    open_window();
    req = 2'b10;
    tick();
    vec++;
    if (gnt !== 2'b10) begin
      errs++;
      $display("FAIL async_pre gnt=%b expected 10", gnt);
    end
    #2 rstn = 1'b0;
    #1;
    vec++;
    if (gnt !== 2'b00 || frame_cnt !== 16'd0 || window !== 1'b0) begin
      errs++;
      $display("FAIL async_reset gnt=%b frame_cnt=%0d window=%b expected 00 0 0", gnt, frame_cnt, window);
    end
    tick();
    tick();
    rstn = 1'b1;
    req  = 2'b00;
    tick();
    open_window();
    req = 2'b11;
    tick();
    vec++;
    if (gnt !== 2'b01) begin
      errs++;
      $display("FAIL async_first_rr gnt=%b expected 01", gnt);
    end
    req = 2'b00;
  endtask

  task automatic model_reset();
    m_lines    = 0;
    m_held     = 0;
    m_last     = 1;
    m_window   = 1'b0;
    m_prev_win = 1'b0;
    m_overrun  = 1'b0;
    m_hs_prev  = 1'b1;
    m_vs_prev  = 1'b1;
    m_gnt      = 2'b00;
    m_frame    = 16'd0;
  endtask

  // Advances the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    logic vsf, hsf, closing;
    int   o;
    vsf     = m_vs_prev && !vsync;
    hsf     = m_hs_prev && !hsync;
    closing = m_window && hsf && !vsf && (m_lines + 1 == WIN);
    m_overrun = 1'b0;
    if (m_gnt != 2'b00) begin
      o = (m_gnt == 2'b10) ? 1 : 0;
      if (closing) begin
        m_gnt     = 2'b00;
        m_overrun = !done[o];
      end else if (done[o] || !req[o] || m_held == BURST - 1) begin
        m_gnt = 2'b00;
      end else begin
        m_held++;
      end
    end else if (m_window && m_prev_win && !closing && req != 2'b00) begin
      o      = req[1 - m_last] ? 1 - m_last : m_last;
      m_gnt  = (o == 1) ? 2'b10 : 2'b01;
      m_held = 0;
      m_last = o;
    end
    m_prev_win = m_window;
    if (vsf) begin
      m_window = 1'b1;
      m_lines  = 0;
      m_frame  = m_frame + 16'd1;
    end else if (m_window && hsf) begin
      m_lines++;
      if (closing) m_window = 1'b0;
    end
    m_hs_prev = hsync;
    m_vs_prev = vsync;
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      hsync = ($urandom_range(0, 3) != 0);
      vsync = !(((c % 220) < 3) || ($urandom_range(0, 399) == 0));
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      done = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      model_step();
      tick();
      vec++;
      if (gnt !== m_gnt) begin
        errs++;
        $display("FAIL rand_gnt cycle=%0d gnt=%b expected %b", c, gnt, m_gnt);
      end
      vec++;
      if (window !== m_window) begin
        errs++;
        $display("FAIL rand_window cycle=%0d window=%b expected %b", c, window, m_window);
      end
      vec++;
      if (overrun !== m_overrun) begin
        errs++;
        $display("FAIL rand_overrun cycle=%0d overrun=%b expected %b", c, overrun, m_overrun);
      end
      vec++;
      if (frame_cnt !== m_frame) begin
        errs++;
        $display("FAIL rand_frame cycle=%0d frame_cnt=%0d expected %0d", c, frame_cnt, m_frame);
      end
    end
    req  = 2'b00;
    done = 2'b00;
  endtask

  initial begin
    test_reset();
    test_window();
    test_round_robin();
    test_burst();
    test_overrun(1'b0);
    test_overrun(1'b1);
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
